// File: rtl/mat_result_streamer_if.sv
// Capture-side and stream-side signals of the matrix result streamer.
// slave is the streamer's view; master is the producer/consumer view.
interface mat_result_streamer_if #(
  parameter int DATA_W = 10
);
  logic              load;
  logic [DATA_W-1:0] S0, S1, S2, S3, S4, S5, S6, S7;
  logic              load_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_row;
  logic              out_col;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              ovf_err;
  logic              clr_err;

  modport slave (
    input  load, S0, S1, S2, S3, S4, S5, S6, S7, out_ready, clr_err,
    output load_ready, out_data, out_row, out_col, out_valid, out_last, busy, ovf_err
  );

  modport master (
    output load, S0, S1, S2, S3, S4, S5, S6, S7, out_ready, clr_err,
    input  load_ready, out_data, out_row, out_col, out_valid, out_last, busy, ovf_err
  );
endinterface

// File: rtl/mat_result_streamer.sv
// Ping-pong buffers one 4x2 result matrix per load and streams it row-major; first beat 1 cycle after load.
// out_ready low freezes the presented beat; load_ready drops only while both banks hold unsent data.
module mat_result_streamer #(
  parameter int DATA_W = 10,
  parameter int N_ELEM = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mat_result_streamer_if.slave   bus
);
  localparam int              IDX_W    = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic { IDLE, STREAM } state_t;

  state_t            state;
  logic [1:0]        count;
  logic              wbank;
  logic              rbank;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_row;
  logic              out_col;
  logic              out_valid;
  logic              out_last;
  logic              ovf_err;

  logic [DATA_W-1:0] s_in [N_ELEM];
  logic [DATA_W-1:0] bank [2][N_ELEM];

  logic              load_ready;
  logic              accept;
  logic              fire;
  logic [IDX_W-1:0]  idx_nxt;

  assign s_in[0] = bus.S0;
  assign s_in[1] = bus.S1;
  assign s_in[2] = bus.S2;
  assign s_in[3] = bus.S3;
  assign s_in[4] = bus.S4;
  assign s_in[5] = bus.S5;
  assign s_in[6] = bus.S6;
  assign s_in[7] = bus.S7;

  // load_ready comes from the registered count only, never from out_ready.
  assign load_ready = (count < 2'd2);
  assign accept     = bus.load & load_ready;
  assign fire       = out_valid & bus.out_ready;
  assign idx_nxt    = idx + 1'b1;

  // Bank storage carries no reset; stale contents are never presented.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N_ELEM; k++) begin
        bank[wbank][k] <= s_in[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 2'd0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      idx       <= '0;
      out_data  <= '0;
      out_row   <= 2'd0;
      out_col   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      case ({accept, fire && (idx == LAST_IDX)})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (accept) begin
        wbank <= ~wbank;
      end

      if (bus.load && !load_ready) begin
        ovf_err <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          // The bank being written this edge is also the read bank, so take element 0 from the inputs.
          if (accept) begin
            state     <= STREAM;
            out_valid <= 1'b1;
            idx       <= '0;
            out_data  <= s_in[0];
            out_row   <= 2'd0;
            out_col   <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        STREAM: begin
          if (fire) begin
            if (idx == LAST_IDX) begin
              rbank    <= ~rbank;
              idx      <= '0;
              out_row  <= 2'd0;
              out_col  <= 1'b0;
              out_last <= 1'b0;
              if (count == 2'd2) begin
                out_data <= bank[~rbank][0];
              end else if (accept) begin
                out_data <= s_in[0];
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_data  <= '0;
              end
            end else begin
              idx      <= idx_nxt;
              out_data <= bank[rbank][idx_nxt];
              out_row  <= idx_nxt[IDX_W-1:1];
              out_col  <= idx_nxt[0];
              out_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.out_data   = out_data;
  assign bus.out_row    = out_row;
  assign bus.out_col    = out_col;
  assign bus.out_valid  = out_valid;
  assign bus.out_last   = out_last;
  assign bus.busy       = (count != 2'd0);
  assign bus.ovf_err    = ovf_err;
endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer: inputs driven and outputs sampled on the falling edge.
module tb_mat_result_streamer;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mat_result_streamer_if #(.DATA_W(10)) bus ();

  mat_result_streamer #(.DATA_W(10), .N_ELEM(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_mat(input logic [9:0] base);
    bus.S0 = base;
    bus.S1 = base + 10'd1;
    bus.S2 = base + 10'd2;
    bus.S3 = base + 10'd3;
    bus.S4 = base + 10'd4;
    bus.S5 = base + 10'd5;
    bus.S6 = base + 10'd6;
    bus.S7 = base + 10'd7;
  endtask

  task automatic check_beat(input string tag, input logic [9:0] base, input int k);
    check({tag, "_vld"},  32'(bus.out_valid), 32'd1);
    check({tag, "_dat"},  32'(bus.out_data), 32'(base) + 32'(k));
    check({tag, "_row"},  32'(bus.out_row), 32'(k / 2));
    check({tag, "_col"},  32'(bus.out_col), 32'(k % 2));
    check({tag, "_last"}, 32'(bus.out_last), (k == 7) ? 32'd1 : 32'd0);
  endtask

  task automatic stream8(input logic [9:0] base, input string tag);
    for (int k = 0; k < 8; k++) begin
      check_beat(tag, base, k);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"},  32'(bus.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_lrdy"}, 32'(bus.load_ready), 32'd1);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.out_ready = 1'b1;
    bus.clr_err   = 1'b0;
    set_mat(10'd0);
    repeat (2) @(negedge clk);

    // Reset state
    check_idle("rst");
    check("rst_dat",  32'(bus.out_data), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_row",  32'(bus.out_row), 32'd0);
    check("rst_col",  32'(bus.out_col), 32'd0);
    check("rst_ovf",  32'(bus.ovf_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single load, ready tied high
    bus.load = 1'b1;
    set_mat(10'd1);
    @(negedge clk);
    bus.load = 1'b0;
    stream8(10'd1, "single");
    check_idle("single_end");

    // Back-to-back loads, rejected third load, clear colliding with a rejected load
    bus.load = 1'b1;
    set_mat(10'd1);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      check_beat("b2b", (k < 8) ? 10'd1 : 10'd11, k % 8);
      check("b2b_lrdy", 32'(bus.load_ready), (k >= 1 && k <= 7) ? 32'd0 : 32'd1);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_ovf",  32'(bus.ovf_err), (k >= 4) ? 32'd1 : 32'd0);
      case (k)
        0: set_mat(10'd11);
        1: bus.load = 1'b0;
        3: begin bus.load = 1'b1; set_mat(10'd50); end
        4: bus.load = 1'b0;
        5: begin bus.load = 1'b1; bus.clr_err = 1'b1; end
        6: begin bus.load = 1'b0; bus.clr_err = 1'b0; end
        default: ;
      endcase
      @(negedge clk);
    end
    check_idle("b2b_end");
    check("ovf_sticky", 32'(bus.ovf_err), 32'd1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    check("ovf_clr", 32'(bus.ovf_err), 32'd0);

    // Backpressure: three stall cycles on beat 4
    begin
      int b;
      int stall;
      logic rdy;
      b = 0;
      stall = 0;
      bus.load = 1'b1;
      set_mat(10'd1);
      @(negedge clk);
      bus.load = 1'b0;
      for (int cyc = 0; cyc < 11 && b < 8; cyc++) begin
        check_beat("stall", 10'd1, b);
        rdy = !(b == 4 && stall < 3);
        if (!rdy) stall++;
        bus.out_ready = rdy;
        @(negedge clk);
        if (rdy) b++;
      end
      bus.out_ready = 1'b1;
      check("stall_beats", 32'(b), 32'd8);
      check("stall_cnt", 32'(stall), 32'd3);
      check_idle("stall_end");
    end

    // Reset in the middle of a stream
    bus.load = 1'b1;
    set_mat(10'd1);
    @(negedge clk);
    bus.load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_beat("prerst", 10'd1, k);
      @(negedge clk);
    end
    check_beat("prerst", 10'd1, 3);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    check("midrst_dat", 32'(bus.out_data), 32'd0);
    check("midrst_row", 32'(bus.out_row), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postrst_vld", 32'(bus.out_valid), 32'd0);
    end
    bus.load = 1'b1;
    set_mat(10'd100);
    @(negedge clk);
    bus.load = 1'b0;
    stream8(10'd100, "postrst");
    check_idle("postrst_end");

    // Load landing on the same edge as the last beat at count=1
    bus.load = 1'b1;
    set_mat(10'd1);
    @(negedge clk);
    bus.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_beat("seam", 10'd1, k);
      if (k == 7) begin
        bus.load = 1'b1;
        set_mat(10'd20);
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    check("seam_busy", 32'(bus.busy), 32'd1);
    check("seam_lrdy", 32'(bus.load_ready), 32'd1);
    stream8(10'd20, "seam2");
    check_idle("seam_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
